ws_tile_sequencer: RTL

//  Job sequencer for one weight-stationary systolic tile (ROWS x COLS PEs, MAC_DELAY-cycle PE pipeline).
//  Per job it:
//   - loads ROWS weight rows into the array,
//   - streams num_vecs activation vectors, gated by credits for the downstream result FIFO,
//   - drains until every result vector has returned.

---
 rtl/ws_tile_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ws_tile_sequencer.sv
// Job sequencer for one weight-stationary systolic tile: loads weight rows, streams
// activation vectors under result-FIFO credit control, then drains until all results return.
module ws_tile_sequencer #(
  parameter int unsigned ROWS          = 32,
  parameter int unsigned COLS          = 32,
  parameter int unsigned MAC_DELAY     = 9,
  parameter int unsigned MAX_VECS      = 64,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned DRAIN_TIMEOUT = ROWS * MAC_DELAY + ROWS + COLS,
  localparam int unsigned VEC_W        = $clog2(MAX_VECS + 1),
  localparam int unsigned ROW_W        = $clog2(ROWS),
  localparam int unsigned CRED_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [VEC_W-1:0]  num_vecs_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic              w_valid_i,
  output logic              w_ready_o,
  output logic [ROW_W-1:0]  w_row_o,
  output logic              arr_w_load_o,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  output logic              arr_a_issue_o,
  input  logic              arr_res_valid_i,
  input  logic              res_pop_i,
  output logic [CRED_W-1:0] credits_o
);

  localparam int unsigned IDLE_W = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [VEC_W-1:0]   r_n, w_n_d;
  logic [ROW_W-1:0]   r_row, w_row_d;
  logic [VEC_W-1:0]   r_issued, w_issued_d;
  logic [VEC_W-1:0]   r_recv, w_recv_d;
  logic [IDLE_W-1:0]  r_idle, w_idle_d;
  logic [CRED_W-1:0]  r_credits, w_credits_d;
  logic               r_err, w_err_d;

  // Outputs decode from registered state only; handshakes combine with the valids.
  assign busy_o        = (r_state != StIdle);
  assign done_o        = (r_state == StDone);
  assign err_o         = r_err;
  assign w_ready_o     = (r_state == StLoadW);
  assign w_row_o       = r_row;
  assign arr_w_load_o  = w_valid_i & w_ready_o;
  assign a_ready_o     = (r_state == StStream) && (r_credits != '0) && (r_issued < r_n);
  assign arr_a_issue_o = a_valid_i & a_ready_o;
  assign credits_o     = r_credits;

  // Next-state: job sequencing, then result accounting, then credit accounting.
  always_comb begin
    w_state_d   = r_state;
    w_n_d       = r_n;
    w_row_d     = r_row;
    w_issued_d  = r_issued;
    w_recv_d    = r_recv;
    w_idle_d    = r_idle;
    w_credits_d = r_credits;
    w_err_d     = r_err;

    case (r_state)
      StIdle: begin
        if (start_i) begin
          w_err_d = 1'b0;
          if (num_vecs_i == '0) begin
            w_state_d = StDone;
          end else if (num_vecs_i > VEC_W'(MAX_VECS)) begin
            w_err_d   = 1'b1;
            w_state_d = StDone;
          end else begin
            w_n_d      = num_vecs_i;
            w_row_d    = '0;
            w_issued_d = '0;
            w_recv_d   = '0;
            w_idle_d   = '0;
            w_state_d  = StLoadW;
          end
        end
      end
      StLoadW: begin
        if (arr_w_load_o) begin
          if (r_row == ROW_W'(ROWS - 1)) begin
            w_row_d   = '0;
            w_state_d = StStream;
          end else begin
            w_row_d = r_row + ROW_W'(1);
          end
        end
      end
      StStream: begin
        if (arr_a_issue_o) begin
          w_issued_d = r_issued + VEC_W'(1);
          if (w_issued_d == r_n) w_state_d = StDrain;
        end
      end
      StDrain: begin
        if (r_recv == r_n) begin
          w_state_d = StDone;
        end else if (arr_res_valid_i) begin
          w_idle_d = '0;
        end else if (r_idle == IDLE_W'(DRAIN_TIMEOUT - 1)) begin
          w_err_d   = 1'b1;
          w_state_d = StDone;
        end else begin
          w_idle_d = r_idle + IDLE_W'(1);
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    // A result is only legal while a job still owes results.
    if (arr_res_valid_i) begin
      if (((r_state == StStream) || (r_state == StDrain)) && (r_recv != r_n)) begin
        w_recv_d = r_recv + VEC_W'(1);
      end else begin
        w_err_d = 1'b1;
      end
    end

    // Issue and pop in the same cycle cancel; a pop with a full credit pool is bogus.
    if (arr_a_issue_o && !res_pop_i) begin
      w_credits_d = r_credits - CRED_W'(1);
    end else if (res_pop_i && !arr_a_issue_o) begin
      if (r_credits == CRED_W'(FIFO_DEPTH)) w_err_d = 1'b1;
      else                                  w_credits_d = r_credits + CRED_W'(1);
    end
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_n       <= '0;
      r_row     <= '0;
      r_issued  <= '0;
      r_recv    <= '0;
      r_idle    <= '0;
      r_credits <= CRED_W'(FIFO_DEPTH);
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_n       <= w_n_d;
      r_row     <= w_row_d;
      r_issued  <= w_issued_d;
      r_recv    <= w_recv_d;
      r_idle    <= w_idle_d;
      r_credits <= w_credits_d;
      r_err     <= w_err_d;
    end
  end

endmodule
